if_fetch_unit: RTL and testbench

- RISC-V instruction fetch stage supporting mixed 16-bit (compressed) and 32-bit instructions.
- Reads 32-bit words from an external synchronous instruction memory and realigns halfwords into whole instructions, including 32-bit instructions that straddle a word boundary.
- Delivers one instruction per cycle to the decoder and redirects on a Jump request from the branch/jump predictor.

---
 rtl/if_fetch_unit.sv | 151 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// RISC-V fetch stage: word fetch, halfword realignment of 16/32-bit instructions, jump redirect.
// Optional FETCH_MISALIGN_EXC_EN adds fetch_misalign and suppresses odd-target jumps.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        Jump,
  input  logic [31:0] prdt_op1,
  input  logic [31:0] prdt_op2,
  input  logic [31:0] insr_mem,
  output logic [31:0] PC,
  output logic        mem_cs,
  output logic [31:0] insr_dec,
  output logic        insr_valid,
  output logic [31:0] insr_pc
`ifdef FETCH_MISALIGN_EXC_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam int VIEW = QDEPTH + 2;

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic [15:0] q_q [QDEPTH];
  logic [15:0] q_d [QDEPTH];
  logic [2:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        pend_drop_q, pend_drop_d;
  logic        drop_next_q, drop_next_d;

  logic        run, jump_take, is32;
  logic [31:0] jump_sum, target;
  logic [2:0]  pend_hw, avail, idx;
  logic [1:0]  need, pop;
  logic [15:0] in_hw [2];
  logic [15:0] view [VIEW];

`ifdef FETCH_MISALIGN_EXC_EN
  logic misalign_q, misalign_d;
  assign fetch_misalign = misalign_q;
`endif

  assign PC = pc_q;

  always_comb begin
    run      = (state_q == RUN);
    jump_sum = prdt_op1 + prdt_op2;
    target   = jump_sum & 32'hFFFF_FFFE;
`ifdef FETCH_MISALIGN_EXC_EN
    jump_take  = run && Jump && !jump_sum[0];
    misalign_d = run && Jump && jump_sum[0];
`else
    jump_take  = run && Jump;
`endif

    // halfwords landing this cycle from the read issued last cycle
    pend_hw  = !pend_q ? 3'd0 : (pend_drop_q ? 3'd1 : 3'd2);
    mem_cs   = run && ((cnt_q + pend_hw) <= 3'd2);
    in_hw[0] = pend_drop_q ? insr_mem[31:16] : insr_mem[15:0];
    in_hw[1] = insr_mem[31:16];
    avail    = cnt_q + pend_hw;

    // queued halfwords followed by the incoming response, in address order
    for (int i = 0; i < VIEW; i++) view[i] = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (3'(i) < cnt_q) view[i] = q_q[i];
    end
    for (int j = 0; j < 2; j++) begin
      idx = cnt_q + 3'(j);
      if (pend_hw > 3'(j)) view[idx] = in_hw[j];
    end

    is32       = (view[0][1:0] == 2'b11);
    need       = is32 ? 2'd2 : 2'd1;
    insr_valid = run && !jump_take && (avail >= {1'b0, need});
    pop        = insr_valid ? need : 2'd0;
    insr_dec   = '0;
    insr_pc    = '0;
    if (insr_valid) begin
      insr_dec = is32 ? {view[1], view[0]} : {16'h0000, view[0]};
      insr_pc  = head_pc_q;
    end

    for (int i = 0; i < QDEPTH; i++) begin
      idx    = 3'(i) + {1'b0, pop};
      q_d[i] = view[idx];
    end
    cnt_d       = avail - {1'b0, pop};
    head_pc_d   = head_pc_q + {29'b0, pop, 1'b0};
    pc_d        = mem_cs ? pc_q + 32'd4 : pc_q;
    pend_d      = mem_cs;
    pend_drop_d = mem_cs && drop_next_q;
    drop_next_d = drop_next_q && !mem_cs;
    state_d     = state_q;

    if (!run && start) begin
      state_d     = RUN;
      pc_d        = {RESET_PC[31:2], 2'b00};
      head_pc_d   = {RESET_PC[31:1], 1'b0};
      drop_next_d = RESET_PC[1];
      cnt_d       = '0;
    end

    // redirect: flush, discard the in-flight word, refetch the target word
    if (jump_take) begin
      cnt_d       = '0;
      pend_d      = 1'b0;
      pend_drop_d = 1'b0;
      pc_d        = {target[31:2], 2'b00};
      head_pc_d   = target;
      drop_next_d = target[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= IDLE;
      pc_q        <= {RESET_PC[31:2], 2'b00};
      head_pc_q   <= {RESET_PC[31:1], 1'b0};
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_drop_q <= 1'b0;
      drop_next_q <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) q_q[i] <= '0;
`ifdef FETCH_MISALIGN_EXC_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      head_pc_q   <= head_pc_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_drop_q <= pend_drop_d;
      drop_next_q <= drop_next_d;
      for (int i = 0; i < QDEPTH; i++) q_q[i] <= q_d[i];
`ifdef FETCH_MISALIGN_EXC_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory model, expected-instruction scoreboard, latency checks.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, Jump;
  logic [31:0] prdt_op1, prdt_op2;
  logic [31:0] insr_mem = 32'h0;
  logic [31:0] PC, insr_dec, insr_pc;
  logic        mem_cs, insr_valid;
`ifdef FETCH_MISALIGN_EXC_EN
  logic        fetch_misalign;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_dec_q[$];

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Jump(Jump),
    .prdt_op1(prdt_op1), .prdt_op2(prdt_op2), .insr_mem(insr_mem),
    .PC(PC), .mem_cs(mem_cs), .insr_dec(insr_dec),
    .insr_valid(insr_valid), .insr_pc(insr_pc)
`ifdef FETCH_MISALIGN_EXC_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [29:0] idx);
    logic [31:0] x;
    if (idx == 30'h0)    return 32'h0000_0513;
    if (idx == 30'h1)    return 32'h4501_4501;
    if (idx == 30'h8D)   return 32'h4581_1111;
    if (idx == 30'h15)   return 32'h0000_4585;
    if (idx == 30'hF5)   return 32'h0293_0001;
    if (idx == 30'hF6)   return 32'h0000_ABCD;
    if (idx == 30'h1805) return 32'h00C5_8593;
    x = {2'b00, idx} * 32'h9E37_79B1;
    return x ^ (x >> 13);
  endfunction

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a[31:2]);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // golden instruction stream starting at byte address a0
  task automatic push_seq(input logic [31:0] a0, input int n);
    logic [31:0] a;
    logic [15:0] h;
    a = a0;
    for (int k = 0; k < n; k++) begin
      h = hw_at(a);
      exp_pc_q.push_back(a);
      if (h[1:0] == 2'b11) begin
        exp_dec_q.push_back({hw_at(a + 32'd2), h});
        a = a + 32'd4;
      end else begin
        exp_dec_q.push_back({16'h0000, h});
        a = a + 32'd2;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic sb_flush();
    exp_pc_q.delete();
    exp_dec_q.delete();
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  always @(posedge clk) insr_mem <= mem_cs ? mem_word(PC[31:2]) : 32'hDEAD_BEEF;

  always @(negedge clk) begin
    if (insr_valid === 1'b1) begin
      if (exp_pc_q.size() == 0) chk("sb_underflow", {31'b0, insr_valid}, 32'd0);
      else begin
        chk("sb_pc", insr_pc, exp_pc_q.pop_front());
        chk("sb_dec", insr_dec, exp_dec_q.pop_front());
      end
    end else begin
      chk("novalid_dec", insr_dec, 32'd0);
    end
  end

  task automatic do_jump(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    t = (a + b) & 32'hFFFF_FFFE;
    cyc();
    Jump = 1'b1; prdt_op1 = a; prdt_op2 = b;
    sb_flush();
    push_seq(t, 40);
    smp();
    chk("jmp_n_valid", {31'b0, insr_valid}, 32'd0);
    cyc();
    Jump = 1'b0; prdt_op1 = '0; prdt_op2 = '0;
    smp();
    chk("jmp_n1_pc", PC, {t[31:2], 2'b00});
    chk("jmp_n1_cs", {31'b0, mem_cs}, 32'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_pc"},    PC, 32'd0);
    chk({tag, "_cs"},    {31'b0, mem_cs}, 32'd0);
    chk({tag, "_valid"}, {31'b0, insr_valid}, 32'd0);
    chk({tag, "_dec"},   insr_dec, 32'd0);
    chk({tag, "_ipc"},   insr_pc, 32'd0);
  endtask

  initial begin
    logic saw_wrap;
    rst_n = 1'b1; start = 1'b0; Jump = 1'b0; prdt_op1 = '0; prdt_op2 = '0;
    repeat (3) begin cyc(); smp(); end
    chk_reset_outs("rst");

    cyc(); rst_n = 1'b0; smp();
    chk("idle_cs", {31'b0, mem_cs}, 32'd0);

    cyc(); Jump = 1'b1; prdt_op1 = 32'h100; smp();
    chk("idle_jmp_cs", {31'b0, mem_cs}, 32'd0);
    cyc(); Jump = 1'b0; prdt_op1 = '0; smp();
    chk("idle_jmp_cs2", {31'b0, mem_cs}, 32'd0);
    chk("idle_jmp_pc", PC, 32'd0);

    cyc(); start = 1'b1; push_seq(32'h0, 40); smp();
    cyc(); start = 1'b0; smp();
    chk("start_pc", PC, 32'd0);
    chk("start_cs", {31'b0, mem_cs}, 32'd1);
    cyc(); smp();
    chk("start_first_valid", {31'b0, insr_valid}, 32'd1);
    repeat (6) begin cyc(); smp(); end

    do_jump(32'h236, 32'h0);
    cyc(); smp();
    chk("j236_valid", {31'b0, insr_valid}, 32'd1);
    chk("j236_ipc", insr_pc, 32'h236);
    repeat (5) begin cyc(); smp(); end

    do_jump(32'h54, 32'h0);
    cyc(); smp();
    chk("j54_valid", {31'b0, insr_valid}, 32'd1);
    chk("j54_ipc", insr_pc, 32'h54);
    repeat (5) begin cyc(); smp(); end

    do_jump(32'h3D6, 32'h0);
    cyc(); smp();
    chk("j3d6_pc2", PC, 32'h3D8);
    chk("j3d6_n2_valid", {31'b0, insr_valid}, 32'd0);
    cyc(); smp();
    chk("j3d6_valid", {31'b0, insr_valid}, 32'd1);
    chk("j3d6_dec", insr_dec, 32'hABCD_0293);
    chk("j3d6_ipc", insr_pc, 32'h3D6);
    repeat (5) begin cyc(); smp(); end

    do_jump(32'h6014, 32'h0);
    cyc(); smp();
    chk("j6014_valid", {31'b0, insr_valid}, 32'd1);
    chk("j6014_dec", insr_dec, 32'h00C5_8593);
    repeat (5) begin cyc(); smp(); end

`ifndef FETCH_MISALIGN_EXC_EN
    do_jump(32'h101, 32'h40);
    cyc(); smp();
    chk("jodd_ipc", insr_pc, 32'h140);
    repeat (5) begin cyc(); smp(); end
`endif

    do_jump(32'hFFFF_FFF0, 32'h8);
    saw_wrap = 1'b0;
    repeat (8) begin
      cyc(); smp();
      if (PC == 32'h0) saw_wrap = 1'b1;
    end
    chk("wrap_pc_zero_seen", {31'b0, saw_wrap}, 32'd1);

    cyc(); rst_n = 1'b1; smp();
    cyc(); sb_flush(); smp();
    chk_reset_outs("mid_rst");
    cyc(); rst_n = 1'b0; Jump = 1'b1; prdt_op1 = 32'h80; smp();
    chk("post_rst_jmp_cs", {31'b0, mem_cs}, 32'd0);
    cyc(); Jump = 1'b0; prdt_op1 = '0; smp();
    chk_reset_outs("post_rst_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
